// File: rtl/clock_set_controller_if.sv
// Button/time-set bus between the UI sequencer and the rest of the clock.
// The master side is the controller; the slave side drives the buttons and live time.
interface clock_set_controller_if;
    logic       btn_mode;
    logic       btn_ok;
    logic       btn_inc;
    logic       btn_dec;
    logic [4:0] cur_hr;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       alarm_active;
    logic       set_time;
    logic [4:0] hr_in;
    logic [5:0] min_in;
    logic [5:0] sec_in;
    logic       set_alarm;
    logic [4:0] alarm_hr_in;
    logic [5:0] alarm_min_in;
    logic       alarm_en_in;
    logic       alarm_clear;
    logic [2:0] mode;

    modport master (
        input  btn_mode, btn_ok, btn_inc, btn_dec,
        input  cur_hr, cur_min, cur_sec, alarm_active,
        output set_time, hr_in, min_in, sec_in,
        output set_alarm, alarm_hr_in, alarm_min_in, alarm_en_in,
        output alarm_clear, mode
    );

    modport slave (
        output btn_mode, btn_ok, btn_inc, btn_dec,
        output cur_hr, cur_min, cur_sec, alarm_active,
        input  set_time, hr_in, min_in, sec_in,
        input  set_alarm, alarm_hr_in, alarm_min_in, alarm_en_in,
        input  alarm_clear, mode
    );
endinterface

// File: rtl/clock_set_controller.sv
// Button-driven edit sequencer for digital_clock: field editing with auto-repeat,
// commit strobes, alarm shadow registers and an inactivity timeout back to RUN.
module clock_set_controller #(
    parameter int HOLD_CYCLES    = 20,
    parameter int REPEAT_CYCLES  = 5,
    parameter int TIMEOUT_CYCLES = 600
) (
    input logic                  clk,
    input logic                  rst_n,
    clock_set_controller_if.master bus
);
    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        SET_SEC  = 3'd3,
        SET_AHR  = 3'd4,
        SET_AMIN = 3'd5
    } state_t;

    localparam int RPT_W = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state;
    logic [4:0]       edit_hr, alarm_hr_q;
    logic [5:0]       edit_min, edit_sec, alarm_min_q;
    logic             alarm_en_q;
    logic             inc_d, dec_d;
    logic [RPT_W-1:0] rpt_cnt, rpt_next;
    logic             rpt_phase;
    logic [TO_W-1:0]  to_cnt;
    logic             set_time_q, set_alarm_q, alarm_clear_q;

    logic in_set, inc_rise, dec_rise, single, rise, rpt_fire, step;
    logic any_event, activity, do_clear, do_ok, do_mode, do_step, to_hit, leave;

    function automatic logic [4:0] hr_step(input logic [4:0] v, input logic up);
        if (up) return (v >= 5'd23) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    function automatic logic [5:0] ms_step(input logic [5:0] v, input logic up);
        if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    // Event decode and per-cycle priority resolution
    always_comb begin
        in_set    = (state != RUN);
        inc_rise  = bus.btn_inc & ~inc_d;
        dec_rise  = bus.btn_dec & ~dec_d;
        single    = bus.btn_inc ^ bus.btn_dec;
        rise      = (inc_rise & ~bus.btn_dec) | (dec_rise & ~bus.btn_inc);
        rpt_next  = rpt_cnt + 1'b1;
        rpt_fire  = single & ~rise & (rpt_phase ? (rpt_next >= RPT_W'(REPEAT_CYCLES))
                                                : (rpt_next >= RPT_W'(HOLD_CYCLES)));
        step      = in_set & single & (rise | rpt_fire);
        any_event = bus.btn_mode | bus.btn_ok | inc_rise | dec_rise;
        activity  = bus.btn_mode | bus.btn_ok | bus.btn_inc | bus.btn_dec;
        do_clear  = bus.alarm_active & any_event;
        do_ok     = ~do_clear & bus.btn_ok;
        do_mode   = ~do_clear & ~bus.btn_ok & bus.btn_mode;
        do_step   = ~do_clear & ~bus.btn_ok & ~bus.btn_mode & step;
        to_hit    = in_set & ~activity & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
        leave     = do_mode | (do_ok & in_set) | to_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            edit_hr       <= '0;
            edit_min      <= '0;
            edit_sec      <= '0;
            alarm_hr_q    <= '0;
            alarm_min_q   <= '0;
            alarm_en_q    <= 1'b0;
            inc_d         <= 1'b0;
            dec_d         <= 1'b0;
            rpt_cnt       <= '0;
            rpt_phase     <= 1'b0;
            to_cnt        <= '0;
            set_time_q    <= 1'b0;
            set_alarm_q   <= 1'b0;
            alarm_clear_q <= 1'b0;
        end else begin
            inc_d         <= bus.btn_inc;
            dec_d         <= bus.btn_dec;
            set_time_q    <= 1'b0;
            set_alarm_q   <= 1'b0;
            alarm_clear_q <= 1'b0;

            // Repeat counter restarts on release, both-held or any state change
            if (leave || !in_set || !single) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b0;
            end else if (rise) begin
                rpt_cnt   <= RPT_W'(1);
                rpt_phase <= 1'b0;
            end else if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b1;
            end else begin
                rpt_cnt   <= rpt_next;
            end

            if (!in_set || activity || to_hit) to_cnt <= '0;
            else                               to_cnt <= to_cnt + 1'b1;

            if (do_clear) begin
                alarm_clear_q <= 1'b1;
            end else if (do_ok) begin
                case (state)
                    RUN: begin
                        alarm_en_q  <= ~alarm_en_q;
                        set_alarm_q <= 1'b1;
                    end
                    SET_HR, SET_MIN, SET_SEC: begin
                        set_time_q <= 1'b1;
                        state      <= RUN;
                    end
                    default: begin
                        alarm_hr_q  <= edit_hr;
                        alarm_min_q <= edit_min;
                        alarm_en_q  <= 1'b1;
                        set_alarm_q <= 1'b1;
                        state       <= RUN;
                    end
                endcase
            end else if (do_mode) begin
                case (state)
                    RUN: begin
                        state    <= SET_HR;
                        edit_hr  <= bus.cur_hr;
                        edit_min <= bus.cur_min;
                        edit_sec <= bus.cur_sec;
                    end
                    SET_HR:  state <= SET_MIN;
                    SET_MIN: state <= SET_SEC;
                    SET_SEC: begin
                        state    <= SET_AHR;
                        edit_hr  <= alarm_hr_q;
                        edit_min <= alarm_min_q;
                    end
                    SET_AHR: state <= SET_AMIN;
                    default: state <= RUN;
                endcase
            end else if (do_step) begin
                case (state)
                    SET_HR, SET_AHR:   edit_hr  <= hr_step(edit_hr, bus.btn_inc);
                    SET_MIN, SET_AMIN: edit_min <= ms_step(edit_min, bus.btn_inc);
                    SET_SEC:           edit_sec <= ms_step(edit_sec, bus.btn_inc);
                    default: ;
                endcase
            end else if (to_hit) begin
                state <= RUN;
            end
        end
    end

    assign bus.set_time     = set_time_q;
    assign bus.hr_in        = edit_hr;
    assign bus.min_in       = edit_min;
    assign bus.sec_in       = edit_sec;
    assign bus.set_alarm    = set_alarm_q;
    assign bus.alarm_hr_in  = alarm_hr_q;
    assign bus.alarm_min_in = alarm_min_q;
    assign bus.alarm_en_in  = alarm_en_q;
    assign bus.alarm_clear  = alarm_clear_q;
    assign bus.mode         = state;
endmodule

// File: tb/tb_clock_set_controller.sv
// Randomized scoreboard bench for clock_set_controller against a field-level
// behavioural model of the edit/commit/auto-repeat/timeout rules.
module tb_clock_set_controller;
    localparam int HOLD = 20;
    localparam int RPT  = 5;
    localparam int TMO  = 600;

    typedef struct {
        int kind;  // 1 = set_time, 2 = set_alarm, 3 = alarm_clear
        int a;
        int b;
        int c;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    clock_set_controller_if bus();

    clock_set_controller #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (RPT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: state as field index, values as plain integers
    int   m_st = 0, m_eh = 0, m_em = 0, m_es = 0;
    int   m_ah = 0, m_am = 0, m_ae = 0;
    int   m_hold = 0, m_idle = 0;
    bit   m_pinc = 0, m_pdec = 0;
    exp_t q[$];

    task automatic model_step();
        bit inc, dec, single, rise, step, ev, act;
        int old, d;
        inc    = bus.btn_inc;
        dec    = bus.btn_dec;
        single = inc ^ dec;
        rise   = single && (inc ? !m_pinc : !m_pdec);
        ev     = bus.btn_mode || bus.btn_ok || (inc && !m_pinc) || (dec && !m_pdec);
        act    = bus.btn_mode || bus.btn_ok || inc || dec;
        old    = m_st;
        d      = inc ? 1 : -1;

        if (old == 0 || !single) m_hold = 0;
        else if (rise)           m_hold = 1;
        else                     m_hold++;
        step = (old != 0) && single &&
               (rise || m_hold == HOLD || (m_hold > HOLD && (m_hold - HOLD) % RPT == 0));

        if (bus.alarm_active && ev) begin
            q.push_back('{3, 0, 0, 0});
        end else if (bus.btn_ok) begin
            if (old == 0) begin
                m_ae = !m_ae;
                q.push_back('{2, m_ah, m_am, m_ae});
            end else if (old <= 3) begin
                q.push_back('{1, m_eh, m_em, m_es});
                m_st = 0;
            end else begin
                m_ah = m_eh;
                m_am = m_em;
                m_ae = 1;
                q.push_back('{2, m_ah, m_am, m_ae});
                m_st = 0;
            end
        end else if (bus.btn_mode) begin
            if (old == 0) begin
                m_eh = int'(bus.cur_hr);
                m_em = int'(bus.cur_min);
                m_es = int'(bus.cur_sec);
            end else if (old == 3) begin
                m_eh = m_ah;
                m_em = m_am;
            end
            m_st = (old == 5) ? 0 : old + 1;
        end else if (step) begin
            if (old == 1 || old == 4) m_eh = (m_eh + d + 24) % 24;
            else if (old == 3)        m_es = (m_es + d + 60) % 60;
            else                      m_em = (m_em + d + 60) % 60;
        end

        if (old == 0 || act) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TMO) m_st = 0;
        end
        if (m_st != old) m_hold = 0;
        m_pinc = inc;
        m_pdec = dec;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_eh = 0; m_em = 0; m_es = 0;
            m_ah = 0; m_am = 0; m_ae = 0;
            m_hold = 0; m_idle = 0; m_pinc = 0; m_pdec = 0;
            q.delete();
        end else begin
            model_step();
        end
    end

    // Monitor: strobes are checked against the queue, visible state against the model
    logic [2:0] got;
    exp_t       e;
    int         want_vec;
    always @(negedge clk) begin
        if (rst_n) begin
            got = {bus.set_time, bus.set_alarm, bus.alarm_clear};
            check("strobe_onehot", int'($countones(got) <= 1), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                want_vec = (e.kind == 1) ? 4 : (e.kind == 2) ? 2 : 1;
                check("strobe_kind", int'(got), want_vec);
                if (e.kind == 1) begin
                    check("set_time_hr", int'(bus.hr_in), e.a);
                    check("set_time_min", int'(bus.min_in), e.b);
                    check("set_time_sec", int'(bus.sec_in), e.c);
                end else if (e.kind == 2) begin
                    check("set_alarm_hr", int'(bus.alarm_hr_in), e.a);
                    check("set_alarm_min", int'(bus.alarm_min_in), e.b);
                    check("set_alarm_en", int'(bus.alarm_en_in), e.c);
                end
            end else begin
                check("spurious_strobe", int'(got), 0);
            end
            check("mode", int'(bus.mode), m_st);
            check("edit_hr", int'(bus.hr_in), m_eh);
            check("edit_min", int'(bus.min_in), m_em);
            check("edit_sec", int'(bus.sec_in), m_es);
            check("alarm_hr", int'(bus.alarm_hr_in), m_ah);
            check("alarm_min", int'(bus.alarm_min_in), m_am);
            check("alarm_en", int'(bus.alarm_en_in), m_ae);
        end
    end

    task automatic tick(input bit m, input bit o, input bit i, input bit d);
        bus.btn_mode = m;
        bus.btn_ok   = o;
        bus.btn_inc  = i;
        bus.btn_dec  = d;
        @(negedge clk);
        #1;
    endtask

    task automatic set_cur(input int h, input int mi, input int s);
        bus.cur_hr  = 5'(h);
        bus.cur_min = 6'(mi);
        bus.cur_sec = 6'(s);
    endtask

    initial begin
        int r, n;
        bus.btn_mode = 0; bus.btn_ok = 0; bus.btn_inc = 0; bus.btn_dec = 0;
        bus.alarm_active = 0;
        set_cur(0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_mode", int'(bus.mode), 0);
        check("rst_hr", int'(bus.hr_in), 0);
        check("rst_alarm_en", int'(bus.alarm_en_in), 0);
        rst_n = 1;

        // Enter edit, then reset mid-edit
        set_cur(10, 20, 30);
        tick(1, 0, 0, 0);
        check("enter_mode", int'(bus.mode), 1);
        check("enter_hr", int'(bus.hr_in), 10);
        check("enter_min", int'(bus.min_in), 20);
        check("enter_sec", int'(bus.sec_in), 30);
        rst_n = 0;
        #1;
        check("midrst_mode", int'(bus.mode), 0);
        check("midrst_hr", int'(bus.hr_in), 0);
        check("midrst_min", int'(bus.min_in), 0);
        check("midrst_sec", int'(bus.sec_in), 0);
        check("midrst_strobes", int'({bus.set_time, bus.set_alarm, bus.alarm_clear}), 0);
        check("midrst_alarm_en", int'(bus.alarm_en_in), 0);
        @(negedge clk);
        #1;
        rst_n = 1;

        // Time set with hour and minute wrap; live clock moves meanwhile
        set_cur(23, 59, 50);
        tick(1, 0, 0, 0);
        set_cur(23, 59, 51);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        set_cur(23, 59, 55);
        tick(0, 1, 0, 0);
        check("tset_strobe", int'(bus.set_time), 1);
        check("tset_hr", int'(bus.hr_in), 0);
        check("tset_min", int'(bus.min_in), 58);
        check("tset_sec", int'(bus.sec_in), 50);
        check("tset_mode", int'(bus.mode), 0);
        tick(0, 0, 0, 0);
        check("tset_one_cycle", int'(bus.set_time), 0);

        // Alarm set through SET_AHR / SET_AMIN, then toggle enable from RUN
        repeat (4) tick(1, 0, 0, 0);
        check("ahr_mode", int'(bus.mode), 4);
        check("ahr_load", int'(bus.hr_in), 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        check("aset_strobe", int'(bus.set_alarm), 1);
        check("aset_hr", int'(bus.alarm_hr_in), 23);
        check("aset_min", int'(bus.alarm_min_in), 1);
        check("aset_en", int'(bus.alarm_en_in), 1);
        tick(0, 1, 0, 0);
        check("atoggle_strobe", int'(bus.set_alarm), 1);
        check("atoggle_en", int'(bus.alarm_en_in), 0);
        check("atoggle_hr", int'(bus.alarm_hr_in), 23);

        // Auto-repeat in SET_MIN from 0
        set_cur(5, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        repeat (HOLD + RPT * 3) tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        check("repeat_min", int'(bus.min_in), 5);
        repeat (10) tick(0, 0, 1, 1);
        tick(0, 0, 0, 0);
        check("both_held_min", int'(bus.min_in), 5);
        tick(0, 1, 0, 0);

        // Alarm clear wins over ok and mode
        bus.alarm_active = 1;
        tick(1, 1, 0, 0);
        check("aclr_strobe", int'(bus.alarm_clear), 1);
        check("aclr_mode", int'(bus.mode), 0);
        check("aclr_en", int'(bus.alarm_en_in), 0);
        bus.alarm_active = 0;
        tick(0, 0, 0, 0);

        // Inactivity timeout
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);
        repeat (TMO - 1) tick(0, 0, 0, 0);
        check("tmo_before", int'(bus.mode), 1);
        tick(0, 0, 0, 0);
        check("tmo_after", int'(bus.mode), 0);

        // Randomized segments
        repeat (300) begin
            r = $urandom_range(0, 99);
            bus.alarm_active = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            if (r < 25) begin
                tick(1, 0, 0, 0);
            end else if (r < 35) begin
                tick(0, 1, 0, 0);
            end else if (r < 40) begin
                tick(1, 1, 0, 0);
            end else if (r < 60) begin
                n = $urandom_range(1, 45);
                repeat (n) tick(0, 0, 1, 0);
            end else if (r < 80) begin
                n = $urandom_range(1, 45);
                repeat (n) tick(0, 0, 0, 1);
            end else if (r < 85) begin
                n = $urandom_range(1, 8);
                repeat (n) tick(0, 0, 1, 1);
            end else if (r < 97) begin
                n = $urandom_range(1, 20);
                repeat (n) tick(0, 0, 0, 0);
            end else begin
                n = $urandom_range(590, 620);
                repeat (n) tick(0, 0, 0, 0);
            end
        end

        bus.alarm_active = 0;
        repeat (3) tick(0, 0, 0, 0);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
